icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache directly upstream of the pipelined MIPS core's fetch stage.
- Consumes the core's `pc` and returns `instr` combinationally on a hit.
- On a miss, asserts `stall` and refills one line from external instruction memory over a simple req/ack word bus.
- The integration wrapper ORs `stall` into the core's fetch/decode stall so fetch holds while the cache refills.

---
 rtl/icache_dm.sv | 101 ++++++++++
 tb/tb_icache_dm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with a word-serial refill over a req/ack bus.
// A hit costs zero cycles; a miss stalls fetch until the whole line is loaded and validated.
//
// state     | meaning
// IDLE      | lookup against pc; a miss latches the line address and starts the refill
// REFILL    | one word request per ack, in order from the line base
// FILL_DONE | write the tag and validate the line unless a flush arrived meanwhile
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - OB - IB;

  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

  state_t          state;
  logic [OB-1:0]   cnt;
  logic [IB-1:0]   missIdx;
  logic [TW-1:0]   missTag;
  logic [LINES-1:0] valid;
  logic            flushSeen;

  logic [31:0]     dataArr [LINES][WORDS];
  logic [TW-1:0]   tagArr  [LINES];

  logic [OB-1:0]   pcWord;
  logic [IB-1:0]   pcIdx;
  logic [TW-1:0]   pcTag;
  logic            hit;
  logic            unusedPcLow;

  assign pcWord      = pc[OB+1:2];
  assign pcIdx       = pc[OB+IB+1:OB+2];
  assign pcTag       = pc[31:OB+IB+2];
  assign unusedPcLow = ^pc[1:0];

  assign hit   = (state == IDLE) && valid[pcIdx] && (tagArr[pcIdx] == pcTag);
  assign stall = !hit;
  assign instr = hit ? dataArr[pcIdx][pcWord] : 32'h0000_0000;

  // Request is a pure decode of state so async reset drops it without waiting for an edge.
  assign mem_req  = (state == REFILL);
  assign mem_addr = mem_req ? {missTag, missIdx, cnt, 2'b00} : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      missIdx   <= '0;
      missTag   <= '0;
      valid     <= '0;
      flushSeen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && !hit) begin
            missIdx <= pcIdx;
            missTag <= pcTag;
            cnt     <= '0;
            state   <= REFILL;
          end
        end
        REFILL: begin
          if (flush) flushSeen <= 1'b1;
          if (mem_ack) begin
            cnt <= cnt + OB'(1);
            if (cnt == OB'(WORDS - 1)) state <= FILL_DONE;
          end
        end
        FILL_DONE: begin
          flushSeen <= 1'b0;
          if (!flushSeen && !flush) valid[missIdx] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (flush) valid <= '0;
    end
  end

  // Data and tags are deliberately left unreset; valid alone gates their use.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) dataArr[missIdx][cnt] <= mem_rdata;
    if (state == FILL_DONE) tagArr[missIdx] <= missTag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: hit vectors from a table, hand-written refill, flush and reset sequences.
// Memory returns dataBase+addr after ackDelay wait cycles.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          ackDelay = 0;
  int          waitCnt = 0;
  int          totalAcks = 0;
  logic [31:0] dataBase = 32'h0000_1000;

  icache_dm #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .instr(instr), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (waitCnt >= ackDelay);
  assign mem_rdata = dataBase + mem_addr;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
    if (mem_req && mem_ack) totalAcks <= totalAcks + 1;
  end

  typedef struct {
    logic [31:0] pc;
    logic        expStall;
    logic [31:0] expInstr;
  } vec_t;

  vec_t vecs [11];

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic applyVecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pc = vecs[i].pc;
      #1;
      check32($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].expStall});
      check32($sformatf("vec%0d instr", i), instr, vecs[i].expInstr);
      check32($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, 32'h0);
      @(negedge clk); #1;
    end
  endtask

  // Holds pc at addr until stall drops, checking the in-order word addresses along the way.
  task automatic fetch(input logic [31:0] addr, input int expStall, input logic [31:0] expInstr,
                       input string nm);
    int n;
    int k;
    n = 0;
    k = 0;
    pc = addr;
    #1;
    while (stall && n < 200) begin
      if (mem_req) check32({nm, " mem_addr"}, mem_addr, {addr[31:4], 4'h0} + 32'(k * 4));
      if (mem_req && mem_ack) k++;
      n++;
      @(negedge clk); #1;
    end
    check32({nm, " stall cycles"}, 32'(n), 32'(expStall));
    check32({nm, " words fetched"}, 32'(k), 32'd4);
    check32({nm, " instr"}, instr, expInstr);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0004, 1'b0, 32'h0000_1004};
    vecs[1]  = '{32'h0000_0008, 1'b0, 32'h0000_1008};
    vecs[2]  = '{32'h0000_000C, 1'b0, 32'h0000_100C};
    vecs[3]  = '{32'h0000_0000, 1'b0, 32'h0000_1000};
    vecs[4]  = '{32'h0000_0104, 1'b0, 32'h0000_1104};
    vecs[5]  = '{32'h0000_010C, 1'b0, 32'h0000_110C};
    vecs[6]  = '{32'h0000_0024, 1'b0, 32'h0000_1024};
    vecs[7]  = '{32'h0000_0028, 1'b0, 32'h0000_1028};
    vecs[8]  = '{32'h0000_002C, 1'b0, 32'h0000_102C};
    vecs[9]  = '{32'h0000_0020, 1'b0, 32'h0000_1020};
    vecs[10] = '{32'h0000_002B, 1'b0, 32'h0000_1028};

    rst = 1'b0;
    pc = 32'h0;
    flush = 1'b0;
    @(negedge clk); #1;
    check32("reset stall", {31'b0, stall}, 32'h1);
    check32("reset instr", instr, 32'h0);
    check32("reset mem_req", {31'b0, mem_req}, 32'h0);
    check32("reset mem_addr", mem_addr, 32'h0);
    @(negedge clk); #1;
    rst = 1'b1;

    fetch(32'h0000_0000, 6, 32'h0000_1000, "cold");
    applyVecs(0, 3);

    fetch(32'h0000_0100, 6, 32'h0000_1100, "conflict");
    applyVecs(4, 5);
    fetch(32'h0000_0000, 6, 32'h0000_1000, "evicted");

    ackDelay = 3;
    fetch(32'h0000_0020, 18, 32'h0000_1020, "slow");
    ackDelay = 0;
    applyVecs(6, 10);

    begin
      int acksBefore;
      acksBefore = totalAcks;
      pc = 32'h0000_0040;
      #1;
      check32("flush detect stall", {31'b0, stall}, 32'h1);
      @(negedge clk); #1;
      check32("flush word0 addr", mem_addr, 32'h0000_0040);
      @(negedge clk); #1;
      check32("flush word1 addr", mem_addr, 32'h0000_0044);
      flush = 1'b1;
      @(negedge clk); #1;
      flush = 1'b0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check32("flush fill_done mem_req", {31'b0, mem_req}, 32'h0);
      check32("flush fill_done stall", {31'b0, stall}, 32'h1);
      check32("flush acks completed", 32'(totalAcks - acksBefore), 32'd4);
      @(negedge clk); #1;
      check32("flushed line still misses", {31'b0, stall}, 32'h1);
      fetch(32'h0000_0040, 6, 32'h0000_1040, "re-refill");
      fetch(32'h0000_0000, 6, 32'h0000_1000, "flushed old line");
    end

    pc = 32'h0000_0080;
    flush = 1'b1;
    #1;
    check32("idle flush stall", {31'b0, stall}, 32'h1);
    @(negedge clk); #1;
    flush = 1'b0;
    check32("idle flush defers refill", {31'b0, mem_req}, 32'h0);
    fetch(32'h0000_0080, 6, 32'h0000_1080, "after idle flush");

    ackDelay = 3;
    pc = 32'h0000_00C0;
    @(negedge clk); #1;
    check32("pre-reset mem_req", {31'b0, mem_req}, 32'h1);
    check32("pre-reset mem_addr", mem_addr, 32'h0000_00C0);
    #2;
    rst = 1'b0;
    #1;
    check32("async reset mem_req", {31'b0, mem_req}, 32'h0);
    check32("async reset mem_addr", mem_addr, 32'h0);
    check32("async reset stall", {31'b0, stall}, 32'h1);
    @(negedge clk); #1;
    rst = 1'b1;
    ackDelay = 0;
    fetch(32'h0000_0000, 6, 32'h0000_1000, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
